// File: rtl/sparc_mem_pkg.sv
// sparc_mem_pkg
//   Shared definitions for the SPARC data-memory path.
//   - DATA_W               : pipeline data word width
//   - SZ_BYTE/SZ_HALF/SZ_WORD : mem_size encodings (2'b11 behaves as a word)
//   - arb_state_e          : arbiter states IDLE / PIPE / DBG
//   - num_beats(size)      : number of byte beats for an access size
package sparc_mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PIPE = 2'd1,
    ST_DBG  = 2'd2
  } arb_state_e;

  // The reserved encoding 2'b11 is treated as a word.
  function automatic logic [2:0] num_beats(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_byte_align.sv
// dmem_byte_align
//   Combinational byte-lane logic shared by the pipeline and debug paths.
//   Store side: picks the byte written on a given beat. Accesses are
//   big-endian, so beat k carries byte (N-1-k) of the right-justified data.
//   Load side: joins the bytes latched on earlier beats with the byte read
//   this cycle, then zero- or sign-extends byte/half results.
// Ports:
//   size      in  access size (SZ_*)
//   beat      in  current beat index
//   wdata     in  right-justified store data
//   rd_sh     in  bytes latched on earlier beats (newest in [7:0])
//   rbyte     in  byte read from the RAM this cycle
//   se        in  sign-extend byte/half loads
//   wbyte     out byte to write on this beat
//   rdata_ext out assembled, extended load result
module dmem_byte_align
  import sparc_mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        beat,
  input  logic [DATA_W-1:0] wdata,
  input  logic [23:0]       rd_sh,
  input  logic [7:0]        rbyte,
  input  logic              se,
  output logic [7:0]        wbyte,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [1:0]  lane;
  logic [15:0] low16;

  function automatic logic [DATA_W-1:0] extend(input logic [15:0] v,
                                               input logic is_half,
                                               input logic sx_en);
    logic signed [7:0]        s8;
    logic signed [15:0]       s16;
    logic signed [DATA_W-1:0] sx;
    s8  = signed'(v[7:0]);
    s16 = signed'(v);
    if (!sx_en)
      sx = is_half ? {16'd0, v} : {24'd0, v[7:0]};
    else if (is_half)
      sx = s16;
    else
      sx = s8;
    return sx;
  endfunction

  always_comb begin
    lane  = 2'(num_beats(size) - 3'd1) - beat;
    wbyte = wdata[{lane, 3'b000} +: 8];
  end

  assign low16 = {rd_sh[7:0], rbyte};

  always_comb begin
    case (size)
      SZ_BYTE: rdata_ext = extend(low16, 1'b0, se);
      SZ_HALF: rdata_ext = extend(low16, 1'b1, se);
      default: rdata_ext = {rd_sh, rbyte};
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Sequences all traffic to the byte-wide, single-ported data RAM for the
//   MEM stage and a debug/loader word port. Each access is split into
//   big-endian byte beats (byte=1, half=2, word=4); beat 0 is issued from
//   IDLE in the grant cycle, remaining beats in PIPE or DBG. mem_stall holds
//   the pipeline while a multi-beat or preempted access is in flight.
//   Debug is forced in once STARVE_MAX pipeline transactions have completed
//   while dbg_req was waiting.
// Optional build macro:
//   DMEM_MISALIGN_TRAP_EN - misaligned half/word pipeline accesses perform
//   no RAM beat, complete in IDLE with no stall and pulse mem_misalign.
// Ports:
//   clk, reset              clock, async active-high reset
//   mem_en/rw/size/se/addr/wdata  MEM-stage request
//   mem_rdata, mem_stall    load result (completing cycle only), stall
//   dbg_req/we/addr/wdata   debug word request (held until dbg_done)
//   dbg_rdata, dbg_done     last debug read word, completion pulse
//   mem_misalign            misalignment trap pulse (macro builds only)
//   ram_addr/we/wdata       RAM byte interface (RAM writes on rising edge)
//   ram_rdata               RAM combinational read byte
module dmem_port_arbiter
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_se,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic              mem_misalign,
`endif
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state, state_nxt;
  logic [1:0]        beat, beat_nxt;
  logic [SW-1:0]     starve_cnt;
  logic [23:0]       rd_sh;

  logic              misalign;
  logic              starve_ok;
  logic              pipe_win, dbg_win;
  logic              dbg_side;
  logic              pipe_done, dbg_last;
  logic              beat_issue;
  logic [1:0]        last_beat, cur_beat;
  logic [ADDR_W-1:0] dbg_base;

  logic [1:0]        al_size;
  logic              al_se;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] c);
    return (c >= STARVE_LIM) ? c : c + 1'b1;
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    case (mem_size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = mem_addr[0];
      default: misalign = |mem_addr[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Arbitration and beat bookkeeping
  assign starve_ok = (starve_cnt < STARVE_LIM);
  assign pipe_win  = (state == ST_IDLE) && mem_en  && (!dbg_req || starve_ok);
  assign dbg_win   = (state == ST_IDLE) && dbg_req && (!mem_en  || !starve_ok);
  assign dbg_side  = dbg_win || (state == ST_DBG);
  assign last_beat = 2'(num_beats(mem_size) - 3'd1);
  assign cur_beat  = (state == ST_IDLE) ? 2'd0 : beat;
  assign dbg_last  = (state == ST_DBG) && (beat == 2'd3);
  // Debug words are always aligned; masking keeps every address bit in use.
  assign dbg_base  = dbg_addr & ~ADDR_W'(3);

  // A trapped access completes in the grant cycle without touching the RAM.
  assign pipe_done = (pipe_win && (misalign || last_beat == 2'd0)) ||
                     ((state == ST_PIPE) && (beat == last_beat));

  assign beat_issue = dbg_side || (state == ST_PIPE) || (pipe_win && !misalign);

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      beat       <= 2'd0;
      starve_cnt <= '0;
      dbg_rdata  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (dbg_win)
        starve_cnt <= '0;
      else if (pipe_done && dbg_req)
        starve_cnt <= sat_inc(starve_cnt);
      if (dbg_last && !dbg_we)
        dbg_rdata <= al_rdata;
    end
  end

  // FSM: next state. Completion always returns to IDLE so a new request
  // is never accepted in the completing cycle.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      ST_IDLE: begin
        beat_nxt = 2'd0;
        if (dbg_win) begin
          state_nxt = ST_DBG;
          beat_nxt  = 2'd1;
        end else if (pipe_win && !misalign && (last_beat != 2'd0)) begin
          state_nxt = ST_PIPE;
          beat_nxt  = 2'd1;
        end
      end
      ST_PIPE: begin
        if (beat == last_beat) begin
          state_nxt = ST_IDLE;
          beat_nxt  = 2'd0;
        end else begin
          beat_nxt = beat + 2'd1;
        end
      end
      ST_DBG: begin
        if (beat == 2'd3) begin
          state_nxt = ST_IDLE;
          beat_nxt  = 2'd0;
        end else begin
          beat_nxt = beat + 2'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        beat_nxt  = 2'd0;
      end
    endcase
  end

  // Read shift register: earlier beats of the current access, newest lowest
  always_ff @(posedge clk) begin
    if (beat_issue)
      rd_sh <= {rd_sh[15:0], ram_rdata};
  end

  assign al_size  = dbg_side ? SZ_WORD   : mem_size;
  assign al_se    = dbg_side ? 1'b0      : mem_se;
  assign al_wdata = dbg_side ? dbg_wdata : mem_wdata;

  dmem_byte_align u_align (
    .size      (al_size),
    .beat      (cur_beat),
    .wdata     (al_wdata),
    .rd_sh     (rd_sh),
    .rbyte     (ram_rdata),
    .se        (al_se),
    .wbyte     (ram_wdata),
    .rdata_ext (al_rdata)
  );

  // FSM: outputs
  always_comb begin
    ram_addr  = mem_addr + ADDR_W'(cur_beat);
    ram_we    = 1'b0;
    mem_rdata = '0;
    dbg_done  = dbg_last;
    mem_stall = mem_en && !pipe_done;
    if (dbg_side) begin
      ram_addr = dbg_base + ADDR_W'(cur_beat);
      ram_we   = dbg_we;
    end else if ((pipe_win && !misalign) || (state == ST_PIPE)) begin
      ram_we = mem_rw;
    end
    if (pipe_done && !mem_rw && !misalign)
      mem_rdata = al_rdata;
    if (reset) begin
      ram_we    = 1'b0;
      mem_rdata = '0;
      dbg_done  = 1'b0;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mem_misalign = pipe_win && misalign && !reset;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  localparam int MSZ = 512;

  logic        clk;
  logic        reset;
  logic        mem_en, mem_rw, mem_se;
  logic [1:0]  mem_size;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_stall;
  logic        dbg_req, dbg_we;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_done;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        mem_misalign;
`endif
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata, ram_rdata;

  logic [7:0]  ram     [MSZ];
  logic [7:0]  ref_mem [MSZ];
  logic        ram_clr;
  logic [31:0] dbg_rd_exp;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_port_arbiter #(.ADDR_W(9), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_size  (mem_size),
    .mem_se    (mem_se),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_rdata (dbg_rdata),
    .dbg_done  (dbg_done),
`ifdef DMEM_MISALIGN_TRAP_EN
    .mem_misalign (mem_misalign),
`endif
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM: combinational read, write on rising edge
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < MSZ; i++) ram[i] <= 8'(i * 7 + 3);
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
  end

  assert property (@(posedge clk) disable iff (reset)
                   (dbg_req && !dbg_done) |=> dbg_req)
    else $error("dbg_req dropped before dbg_done");

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbeats(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic is_misal(input logic [1:0] sz, input int a);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
`else
    return (sz == 2'b11) && (a < 0);
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic se, input int a);
    logic [31:0] v;
    int n;
    v = 32'd0;
    n = nbeats(sz);
    for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[(a + k) % MSZ]);
    if (se && n == 1) v = {{24{v[7]}}, v[7:0]};
    else if (se && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
    int n;
    n = nbeats(sz);
    for (int k = 0; k < n; k++) ref_mem[(a + k) % MSZ] = wd[8 * (n - 1 - k) +: 8];
  endtask

  // ---------------- transactions (start and end at posedge+1) ----------------
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    dbg_rd_exp = 32'd0;
  endtask

  task automatic pipe_op(input string tag, input logic rw, input logic [1:0] sz,
                         input logic se, input int a, input logic [31:0] wd);
    int n, stalls;
    logic done, trap, zero_ok, we_at_done, mis_at_done;
    logic [31:0] exp, got;
    n = nbeats(sz);
    trap = is_misal(sz, a);
    exp = (rw || trap) ? 32'd0 : ref_load(sz, se, a);
    mem_en = 1'b1; mem_rw = rw; mem_size = sz; mem_se = se;
    mem_addr = 9'(a); mem_wdata = wd;
    stalls = 0; done = 1'b0; zero_ok = 1'b1; got = 32'd0;
    we_at_done = 1'b0; mis_at_done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!mem_stall) begin
        done = 1'b1;
        got = mem_rdata;
        we_at_done = ram_we;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_at_done = mem_misalign;
`endif
      end else begin
        stalls++;
        if (mem_rdata !== 32'd0) zero_ok = 1'b0;
      end
      @(posedge clk); #1;
    end
    mem_en = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " stalls"}, 32'(stalls), trap ? 32'd0 : 32'(n - 1));
    if (!rw) chk({tag, " rdata"}, got, exp);
    if (n > 1 && !trap) chk({tag, " rdata zero while stalled"}, 32'(zero_ok), 32'd1);
    if (trap) chk({tag, " trap ram_we"}, 32'(we_at_done), 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk({tag, " misalign pulse"}, 32'(mis_at_done), 32'(trap));
`else
    if (mis_at_done) chk({tag, " misalign"}, 32'd1, 32'd0);
`endif
    if (rw && !trap) ref_store(sz, a, wd);
  endtask

  task automatic dbg_op(input string tag, input logic we, input int a, input logic [31:0] wd);
    int cyc, base;
    logic seen;
    base = a - (a % 4);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = 9'(a); dbg_wdata = wd;
    cyc = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      cyc++;
      if (dbg_done) seen = 1'b1;
      @(posedge clk); #1;
    end
    dbg_req = 1'b0;
    chk({tag, " dbg_done seen"}, 32'(seen), 32'd1);
    chk({tag, " dbg cycles"}, 32'(cyc), 32'd4);
    if (we) ref_store(2'b10, base, wd);
    else dbg_rd_exp = ref_load(2'b10, 1'b0, base);
    @(negedge clk);
    chk({tag, " dbg_rdata"}, dbg_rdata, dbg_rd_exp);
    chk({tag, " dbg_done one pulse"}, 32'(dbg_done), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int comp, srun, ndone, comp_at, stall_at, post, rd_bad, bad;
    logic drop, stop;
    logic [31:0] ld_exp, dexp;

    reset = 1'b1; ram_clr = 1'b1;
    mem_en = 1'b0; mem_rw = 1'b0; mem_size = 2'b00; mem_se = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dbg_rd_exp = 32'd0;
    for (int i = 0; i < MSZ; i++) ref_mem[i] = 8'(i * 7 + 3);

    @(posedge clk); #1 ram_clr = 1'b0;
    @(negedge clk);
    chk("reset dbg_rdata", dbg_rdata, 32'd0);
    chk("reset dbg_done", 32'(dbg_done), 32'd0);
    chk("reset mem_rdata", mem_rdata, 32'd0);
    chk("reset ram_we", 32'(ram_we), 32'd0);
    chk("reset mem_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // word store/load, big-endian layout
    pipe_op("st w 56", 1'b1, 2'b10, 1'b0, 56, 32'hDEADBEEF);
    chk("ram[56]", 32'(ram[56]), 32'h0DE);
    chk("ram[57]", 32'(ram[57]), 32'h0AD);
    chk("ram[58]", 32'(ram[58]), 32'h0BE);
    chk("ram[59]", 32'(ram[59]), 32'h0EF);
    pipe_op("ld w 56", 1'b0, 2'b10, 1'b0, 56, 32'd0);
    pipe_op("ld b 57 se", 1'b0, 2'b00, 1'b1, 57, 32'd0);
    pipe_op("ld b 57 ze", 1'b0, 2'b00, 1'b0, 57, 32'd0);

    // half store at the top of the address space
    pipe_op("st h 510", 1'b1, 2'b01, 1'b0, 510, 32'h00001234);
    chk("ram[510]", 32'(ram[510]), 32'h012);
    chk("ram[511]", 32'(ram[511]), 32'h034);
    pipe_op("ld h 510", 1'b0, 2'b01, 1'b0, 510, 32'd0);
    pipe_op("ld h 510 se", 1'b0, 2'b01, 1'b1, 510, 32'd0);

    // debug port alone
    dbg_op("dbg wr 200", 1'b1, 202, 32'hCAFEF00D);
    dbg_op("dbg rd 200", 1'b0, 200, 32'd0);
    pipe_op("ld w 200", 1'b0, 2'b10, 1'b0, 200, 32'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
    pipe_op("mis ld w 57", 1'b0, 2'b10, 1'b0, 57, 32'd0);
    pipe_op("mis st h 57", 1'b1, 2'b01, 1'b0, 57, 32'h0000AAAA);
`endif

    // starvation: continuous word loads with debug waiting
    do_reset();
    ld_exp = ref_load(2'b10, 1'b0, 100);
    dexp   = ref_load(2'b10, 1'b0, 200);
    mem_en = 1'b1; mem_rw = 1'b0; mem_size = 2'b10; mem_se = 1'b0;
    mem_addr = 9'd100; mem_wdata = 32'd0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'd200; dbg_wdata = 32'd0;
    comp = 0; srun = 0; ndone = 0; comp_at = -1; stall_at = -1;
    post = 0; rd_bad = 0; stop = 1'b0;
    for (int c = 0; c < 80 && !stop; c++) begin
      @(negedge clk);
      drop = 1'b0;
      if (!mem_stall) begin
        comp++;
        if (mem_rdata !== ld_exp) rd_bad++;
        if (ndone > 0) post++;
        srun = 0;
      end else begin
        srun++;
      end
      if (dbg_done) begin
        ndone++;
        if (ndone == 1) begin comp_at = comp; stall_at = srun; end
        drop = 1'b1;
      end
      @(posedge clk); #1;
      if (drop) dbg_req = 1'b0;
      if (post >= 2) stop = 1'b1;
    end
    mem_en = 1'b0;
    chk("starve finished", 32'(stop), 32'd1);
    chk("starve completions before debug", 32'(comp_at), 32'd4);
    chk("starve stall cycles through debug", 32'(stall_at), 32'd4);
    chk("starve dbg_done pulses", 32'(ndone), 32'd1);
    chk("starve load data errors", 32'(rd_bad), 32'd0);
    dbg_rd_exp = dexp;
    @(negedge clk);
    chk("starve dbg_rdata", dbg_rdata, dbg_rd_exp);
    @(posedge clk); #1;

    // reset in the middle of a word store
    pipe_op("st w 0", 1'b1, 2'b10, 1'b0, 0, 32'h11223344);
    mem_en = 1'b1; mem_rw = 1'b1; mem_size = 2'b10; mem_se = 1'b0;
    mem_addr = 9'd0; mem_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid beat2 ram_addr", 32'(ram_addr), 32'd2);
    chk("mid beat2 ram_we", 32'(ram_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async rst ram_we", 32'(ram_we), 32'd0);
    chk("async rst beat cleared", 32'(ram_addr), 32'd0);
    chk("async rst stall from idle", 32'(mem_stall), 32'd1);
    mem_en = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    dbg_rd_exp = 32'd0;
    ref_mem[0] = 8'hA1;
    ref_mem[1] = 8'hB2;
    chk("partial ram[0]", 32'(ram[0]), 32'h0A1);
    chk("partial ram[1]", 32'(ram[1]), 32'h0B2);
    chk("partial ram[2]", 32'(ram[2]), 32'h033);
    chk("partial ram[3]", 32'(ram[3]), 32'h044);
    @(negedge clk);
    chk("rst dbg_rdata", dbg_rdata, 32'd0);
    @(posedge clk); #1;

    // randomized mix
    for (int i = 0; i < 80; i++) begin
      int a;
      logic [31:0] wd;
      logic [1:0] sz;
      a  = int'($urandom_range(0, MSZ - 1));
      wd = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)
        dbg_op("rnd dbg", 1'($urandom_range(0, 1)), a, wd);
      else
        pipe_op("rnd pipe", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    bad = 0;
    for (int i = 0; i < MSZ; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("final ram bytes differing", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
